// File: rtl/frame_burst_writer_if.sv
// Avalon-MM burst write bus between frame_burst_writer (master) and the SDRAM port (slave).
interface sdram_ifc #(
  parameter int WIDTH_ADDR = 32,
  parameter int WIDTH_DATA = 64,
  parameter int WIDTH_BE   = 8
);
  logic [WIDTH_ADDR-1:0] address;
  logic [7:0]            burstcount;
  logic                  waitrequest;
  logic [WIDTH_DATA-1:0] writedata;
  logic [WIDTH_BE-1:0]   byteenable;
  logic                  write;

  modport sdram_write_master_port (
    output address, burstcount, writedata, byteenable, write,
    input  waitrequest
  );

  modport slave (
    input  address, burstcount, writedata, byteenable, write,
    output waitrequest
  );
endinterface

// File: rtl/frame_burst_writer.sv
// Buffers a video word stream in a show-ahead FIFO and writes it to SDRAM as fixed-length
// Avalon-MM bursts, ping-ponging between two frame buffers.
module frame_burst_writer #(
  parameter int                    WIDTH_ADDR  = 32,
  parameter int                    WIDTH_DATA  = 64,
  parameter int                    WIDTH_BE    = 8,
  parameter int                    BURST_LEN   = 16,
  parameter int                    FIFO_DEPTH  = 64,
  parameter int                    FRAME_WORDS = 4096,
  parameter logic [WIDTH_ADDR-1:0] BASE_ADDR   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH_DATA-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  sdram_ifc.sdram_write_master_port sdram,
  output logic                  frame_done,
  output logic                  rd_buf,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FCNT_W = $clog2(FRAME_WORDS + 1);
  localparam int OFF_W  = $clog2(FRAME_WORDS + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  typedef enum logic { WAIT_SOF, IN_FRAME } in_state_t;
  typedef enum logic { IDLE, BURST } wr_state_t;

  in_state_t             in_state_q;
  logic [FCNT_W-1:0]     fcnt_q;
  logic                  overflow_q;
  logic                  frame_err_q;

  logic [WIDTH_DATA-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;

  wr_state_t             wr_state_q;
  logic                  write_q;
  logic [WIDTH_ADDR-1:0] address_q;
  logic [7:0]            burstcount_q;
  logic [WIDTH_DATA-1:0] writedata_q;
  logic [BEAT_W-1:0]     beat_cnt_q;
  logic [OFF_W-1:0]      beat_off_q;
  logic                  wr_buf_q;
  logic                  rd_buf_q;
  logic                  frame_done_q;

  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  fifo_full;
  logic [WIDTH_ADDR-1:0] burst_addr;

  assign push_req  = in_valid && (in_state_q == IN_FRAME || in_sof);
  assign pop       = write_q && !sdram.waitrequest;
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push_req && (!fifo_full || pop);

  assign burst_addr = BASE_ADDR
                    + (wr_buf_q ? WIDTH_ADDR'(FRAME_WORDS) : '0)
                    + WIDTH_ADDR'(beat_off_q);

  // ---- input framing: WAIT_SOF / IN_FRAME
  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_q  <= WAIT_SOF;
      fcnt_q      <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (in_valid && in_sof && in_state_q == IN_FRAME) begin
        frame_err_q <= 1'b1;
      end
      // Dropped words still count so every frame is FRAME_WORDS long on the input side.
      if (push_req) begin
        if (!push_ok) begin
          overflow_q <= 1'b1;
        end
        if (fcnt_q == FCNT_W'(FRAME_WORDS - 1)) begin
          fcnt_q     <= '0;
          in_state_q <= WAIT_SOF;
        end else begin
          fcnt_q     <= fcnt_q + FCNT_W'(1);
          in_state_q <= IN_FRAME;
        end
      end
    end
  end

  // ---- FIFO storage and occupancy
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // ---- burst writer: IDLE / BURST with registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q   <= IDLE;
      write_q      <= 1'b0;
      address_q    <= '0;
      burstcount_q <= '0;
      writedata_q  <= '0;
      beat_cnt_q   <= '0;
      beat_off_q   <= '0;
      wr_buf_q     <= 1'b0;
      rd_buf_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (wr_state_q)
        IDLE: begin
          if (count_q >= CNT_W'(BURST_LEN)) begin
            wr_state_q   <= BURST;
            write_q      <= 1'b1;
            address_q    <= burst_addr;
            burstcount_q <= 8'(BURST_LEN);
            writedata_q  <= mem_q[rd_ptr_q];
            beat_cnt_q   <= '0;
          end
        end
        BURST: begin
          if (!sdram.waitrequest) begin
            // Preload the entry behind the head so the next beat follows without a bubble.
            writedata_q <= mem_q[rd_ptr_q + PTR_W'(1)];
            if (beat_cnt_q == BEAT_W'(BURST_LEN - 1)) begin
              write_q    <= 1'b0;
              wr_state_q <= IDLE;
              if (beat_off_q == OFF_W'(FRAME_WORDS - BURST_LEN)) begin
                beat_off_q   <= '0;
                rd_buf_q     <= wr_buf_q;
                wr_buf_q     <= ~wr_buf_q;
                frame_done_q <= 1'b1;
              end else begin
                beat_off_q <= beat_off_q + OFF_W'(BURST_LEN);
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            end
          end
        end
        default: wr_state_q <= IDLE;
      endcase
    end
  end

  assign sdram.address    = address_q;
  assign sdram.burstcount = burstcount_q;
  assign sdram.writedata  = writedata_q;
  assign sdram.byteenable = '1;
  assign sdram.write      = write_q;

  assign frame_done = frame_done_q;
  assign rd_buf     = rd_buf_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_frame_burst_writer.sv
// Randomized scoreboard bench for frame_burst_writer: the stimulus side feeds a queue-based
// reference model, a negedge monitor checks every accepted beat and the status outputs.
module tb_frame_burst_writer;

  localparam int          WA   = 32;
  localparam int          WD   = 64;
  localparam int          WB   = 8;
  localparam int          BL   = 4;
  localparam int          FD   = 16;
  localparam int          FW   = 16;
  localparam logic [31:0] BASE = 32'h1000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [WD-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          frame_done, rd_buf, overflow, frame_err;

  sdram_ifc #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .WIDTH_BE(WB)) sdram_if ();

  frame_burst_writer #(
    .WIDTH_ADDR(WA), .WIDTH_DATA(WD), .WIDTH_BE(WB), .BURST_LEN(BL),
    .FIFO_DEPTH(FD), .FRAME_WORDS(FW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .sdram(sdram_if), .frame_done(frame_done), .rd_buf(rd_buf),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: words that must reach memory, in order, and expected sticky flags.
  logic [WD-1:0] exp_q[$];
  bit m_inframe;
  int m_cnt;
  int m_occ;
  bit ovf_cur, ovf_nxt, ferr_cur, ferr_nxt;

  // Monitor state.
  int          beats;
  int          bb;
  bit          fd_pend;
  bit          rd_exp;
  bit          in_reset = 1'b1;
  bit          hold_v;
  logic [31:0] h_addr;
  logic [7:0]  h_bc;
  logic [63:0] h_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_update(input bit v, input bit s, input logic [63:0] d, input bit pop);
    bit take;
    take = 1'b0;
    ovf_cur = ovf_nxt;
    ferr_cur = ferr_nxt;
    if (v) begin
      if (m_inframe) begin
        take = 1'b1;
        if (s) ferr_nxt = 1'b1;
      end else if (s) begin
        take = 1'b1;
        m_inframe = 1'b1;
      end
    end
    if (take) begin
      m_cnt++;
      if (m_cnt == FW) begin
        m_cnt = 0;
        m_inframe = 1'b0;
      end
      if (m_occ < FD || pop) begin
        exp_q.push_back(d);
        m_occ++;
      end else begin
        ovf_nxt = 1'b1;
      end
    end
    if (pop) m_occ--;
  endtask

  // Called at posedge+1: drives one cycle of inputs and advances to the next posedge+1.
  task automatic step(input bit v, input bit s, input logic [63:0] d, input bit wr);
    in_valid = v;
    in_sof = s;
    in_data = d;
    sdram_if.waitrequest = wr;
    model_update(v, s, d, sdram_if.write && !wr);
    @(posedge clk);
    #1;
  endtask

  function automatic bit wr_pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic send_words(input int n, input bit first_sof, input int extra_sof_at, input int wrmode);
    for (int i = 0; i < n; i++) begin
      step(1'b1, (i == 0 && first_sof) || (i == extra_sof_at), rand64(), wr_pick(wrmode));
    end
  endtask

  task automatic drain(input string name, input int maxc);
    int c;
    c = 0;
    while ((m_occ >= BL || sdram_if.write) && c < maxc) begin
      step(1'b0, 1'b0, '0, 1'b0);
      c++;
    end
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (c >= maxc) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d cycles required=<%0d", name, c, maxc);
    end
    chk({name, "_residual"}, 64'(exp_q.size()), 64'(m_occ));
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    reset = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_data = '0;
    sdram_if.waitrequest = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_write", 64'(sdram_if.write), 64'd0);
    chk("rst_address", 64'(sdram_if.address), 64'd0);
    chk("rst_burstcount", 64'(sdram_if.burstcount), 64'd0);
    chk("rst_writedata", sdram_if.writedata, 64'd0);
    chk("rst_byteenable", 64'(sdram_if.byteenable), 64'hFF);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_rd_buf", 64'(rd_buf), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    m_inframe = 1'b0;
    m_cnt = 0;
    m_occ = 0;
    ovf_cur = 1'b0; ovf_nxt = 1'b0; ferr_cur = 1'b0; ferr_nxt = 1'b0;
    beats = 0; bb = 0; fd_pend = 1'b0; rd_exp = 1'b0; hold_v = 1'b0;
    in_reset = 1'b0;
  endtask

  // Monitor: beats are accepted on the coming posedge when write && !waitrequest.
  always @(negedge clk) begin
    if (!in_reset) begin
      logic [63:0] e;
      logic [31:0] ea;
      chk("frame_done", 64'(frame_done), 64'(fd_pend));
      chk("rd_buf", 64'(rd_buf), 64'(rd_exp));
      chk("overflow", 64'(overflow), 64'(ovf_cur));
      chk("frame_err", 64'(frame_err), 64'(ferr_cur));
      if (hold_v) begin
        chk("stall_write", 64'(sdram_if.write), 64'd1);
        chk("stall_address", 64'(sdram_if.address), 64'(h_addr));
        chk("stall_burstcount", 64'(sdram_if.burstcount), 64'(h_bc));
        chk("stall_writedata", sdram_if.writedata, h_data);
      end
      hold_v = sdram_if.write && sdram_if.waitrequest;
      h_addr = sdram_if.address;
      h_bc = sdram_if.burstcount;
      h_data = sdram_if.writedata;
      fd_pend = 1'b0;
      if (!sdram_if.write) bb = 0;
      if (sdram_if.write && !sdram_if.waitrequest) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected actual=%0h required=no beat", sdram_if.writedata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", sdram_if.writedata, e);
        end
        ea = BASE + 32'(((beats / FW) % 2) * FW) + 32'(((beats % FW) / BL) * BL);
        chk("beat_address", 64'(sdram_if.address), 64'(ea));
        chk("beat_burstcount", 64'(sdram_if.burstcount), 64'(BL));
        chk("beat_byteenable", 64'(sdram_if.byteenable), 64'hFF);
        bb++;
        chk("beats_in_burst_over_limit", 64'(bb > BL), 64'd0);
        beats++;
        if (beats % FW == 0) begin
          fd_pend = 1'b1;
          rd_exp = 1'(((beats / FW) - 1) % 2);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    sdram_if.waitrequest = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // One frame, no stalls.
    send_words(FW, 1'b1, -1, 0);
    drain("frame1", 200);
    chk("frame1_beats", 64'(beats), 64'(FW));
    chk("frame1_rd_buf", 64'(rd_buf), 64'd0);

    // Second frame lands in buffer 1, third wraps back to buffer 0.
    send_words(FW, 1'b1, -1, 0);
    drain("frame2", 200);
    chk("frame2_rd_buf", 64'(rd_buf), 64'd1);
    send_words(FW, 1'b1, -1, 0);
    drain("frame3", 200);
    chk("frame3_rd_buf", 64'(rd_buf), 64'd0);

    // Random 50% waitrequest over two frames.
    send_words(FW, 1'b1, -1, 1);
    send_words(FW, 1'b1, -1, 1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, '0, wr_pick(1));
    drain("rand_stall", 300);

    // Words before the first sof are discarded; an sof mid-frame flags an error.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rand64(), 1'b0);
    send_words(FW, 1'b1, 8, 0);
    drain("sof_err", 200);
    chk("sof_err_flag", 64'(frame_err), 64'd1);
    chk("sof_err_beats", 64'(beats), 64'(FW));

    // Long stall while streaming frames overruns the FIFO.
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, (i % FW) == 0, rand64(), 1'b1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    drain("ovf", 300);
    chk("ovf_frame_beats", 64'(beats), 64'(FW));

    // Reset in the middle of a burst abandons it; the next frame restarts at BASE.
    do_reset();
    n = 0;
    step(1'b1, 1'b1, rand64(), 1'b1);
    while (!sdram_if.write && n < 20) begin
      step(1'b1, 1'b0, rand64(), 1'b1);
      n++;
    end
    chk("midburst_write_seen", 64'(sdram_if.write), 64'd1);
    do_reset();
    send_words(FW, 1'b1, -1, 1);
    drain("post_reset", 300);
    chk("post_reset_beats", 64'(beats), 64'(FW));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
